// File: rtl/rede_out_collect.sv
// rtl/rede_out_collect.sv - per-channel output FIFOs merged round-robin into one valid/ready stream; OUT_COLLECT_DROP_OLDEST_EN selects overwrite-oldest on full
module rede_out_collect #(
    parameter int NUBITS = 31,
    parameter int NUIOOU = 4,
    parameter int FAW    = 3,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [NUIOOU-1:0] out_en,
    output logic [NUBITS-1:0] m_data,
    output logic [CW-1:0]     m_chan,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [NUIOOU-1:0] ovf,
    input  logic              ovf_clr,
    output logic [NUIOOU-1:0] empty
);
    localparam int            DEPTH    = 1 << FAW;
    localparam logic [FAW:0]  CNT_FULL = (FAW+1)'(DEPTH);
    localparam logic [FAW:0]  CNT_ONE  = 1;
    localparam logic [FAW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CH_ONE   = 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(NUIOOU - 1);

    logic [NUBITS-1:0] mem [NUIOOU][DEPTH];
    logic [FAW-1:0]    wptr [NUIOOU];
    logic [FAW-1:0]    rptr [NUIOOU];
    logic [FAW:0]      count [NUIOOU];
    logic [FAW:0]      count_nxt [NUIOOU];
    logic [NUIOOU-1:0] full;
    logic [NUIOOU-1:0] pop;
    logic [NUIOOU-1:0] push;
    logic [NUIOOU-1:0] adv_rd;
    logic [NUIOOU-1:0] ovf_set;
    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     sel;
    logic              found;
    logic              load;
    logic [NUBITS-1:0] head;

    // The output register may take a new word when it is empty or its word leaves this cycle.
    assign load = !m_valid || m_ready;
    assign head = mem[sel][rptr[sel]];

    // Round-robin search: first non-empty channel starting at rr_ptr, wrapping.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUIOOU; i++) begin
            c = (int'(rr_ptr) + i) % NUIOOU;
            if (!found && count[c] != '0) begin
                found = 1'b1;
                sel   = CW'(c);
            end
        end
    end

    // Per-channel push/pop decisions; a pop in the same cycle frees the slot for a write to a full FIFO.
    always_comb begin
        for (int k = 0; k < NUIOOU; k++) begin
            pop[k]     = load && found && (sel == CW'(k));
            full[k]    = (count[k] == CNT_FULL);
            ovf_set[k] = out_en[k] && full[k] && !pop[k];
`ifdef OUT_COLLECT_DROP_OLDEST_EN
            push[k]    = out_en[k];
            adv_rd[k]  = pop[k] || ovf_set[k];
`else
            push[k]    = out_en[k] && !ovf_set[k];
            adv_rd[k]  = pop[k];
`endif
            count_nxt[k] = count[k];
            if (push[k] && !adv_rd[k]) begin
                count_nxt[k] = count[k] + CNT_ONE;
            end else if (!push[k] && adv_rd[k]) begin
                count_nxt[k] = count[k] - CNT_ONE;
            end
        end
    end

    // FIFO storage; contents need no reset because pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOOU; k++) begin
            if (push[k]) begin
                mem[k][wptr[k]] <= io_out;
            end
        end
    end

    // FIFO pointers, occupancy and registered empty flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUIOOU; k++) begin
                wptr[k]  <= '0;
                rptr[k]  <= '0;
                count[k] <= '0;
            end
            empty <= '1;
        end else begin
            for (int k = 0; k < NUIOOU; k++) begin
                if (push[k]) begin
                    wptr[k] <= wptr[k] + PTR_ONE;
                end
                if (adv_rd[k]) begin
                    rptr[k] <= rptr[k] + PTR_ONE;
                end
                count[k] <= count_nxt[k];
                empty[k] <= (count_nxt[k] == '0);
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_chan  <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            if (found) begin
                m_valid <= 1'b1;
                m_data  <= head;
                m_chan  <= sel;
                rr_ptr  <= (sel == CH_LAST) ? '0 : sel + CH_ONE;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow flags; a fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else if (ovf_clr) begin
            ovf <= ovf_set;
        end else begin
            ovf <= ovf | ovf_set;
        end
    end

endmodule

// File: tb/tb_rede_out_collect.sv
// tb/tb_rede_out_collect.sv - randomized and directed bench for rede_out_collect against a queue-based model
module tb_rede_out_collect;
    localparam int NB    = 31;
    localparam int NC    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] io_out;
    logic [NC-1:0] out_en;
    logic [NB-1:0] m_data;
    logic [CW-1:0] m_chan;
    logic          m_valid;
    logic          m_ready;
    logic [NC-1:0] ovf;
    logic          ovf_clr;
    logic [NC-1:0] empty;

    always #5 clk = ~clk;

    rede_out_collect #(.NUBITS(NB), .NUIOOU(NC), .FAW(3), .CW(CW)) dut (
        .clk(clk), .rst(rst), .io_out(io_out), .out_en(out_en),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid), .m_ready(m_ready),
        .ovf(ovf), .ovf_clr(ovf_clr), .empty(empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [NB-1:0] mq[NC][$];
    logic          mv;
    logic [NB-1:0] md;
    int            mc;
    int            rr;
    logic [NC-1:0] movf;
    logic [NC-1:0] memp;

    logic [NB-1:0] got_d[$];
    int            got_c[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) mq[k].delete();
        mv = 1'b0; md = '0; mc = 0; rr = 0; movf = '0; memp = '1;
    endtask

    // Next state from the current inputs, evaluated just before the clock edge.
    task automatic model_step();
        int sz[NC];
        int sel;
        logic [NC-1:0] popped;
        logic [NC-1:0] nov;
        sel = -1; popped = '0; nov = '0;
        for (int k = 0; k < NC; k++) sz[k] = mq[k].size();
        if (!mv || m_ready) begin
            for (int i = 0; i < NC; i++) begin
                if (sel < 0 && sz[(rr + i) % NC] > 0) sel = (rr + i) % NC;
            end
            if (sel >= 0) begin
                md = mq[sel].pop_front();
                mc = sel;
                mv = 1'b1;
                rr = (sel + 1) % NC;
                popped[sel] = 1'b1;
            end else begin
                mv = 1'b0;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (out_en[k]) begin
                if (sz[k] < DEPTH || popped[k]) begin
                    mq[k].push_back(io_out);
                end else begin
                    nov[k] = 1'b1;
`ifdef OUT_COLLECT_DROP_OLDEST_EN
                    void'(mq[k].pop_front());
                    mq[k].push_back(io_out);
`endif
                end
            end
        end
        movf = ovf_clr ? nov : (movf | nov);
        for (int k = 0; k < NC; k++) memp[k] = (mq[k].size() == 0);
    endtask

    task automatic compare_all();
        check("m_valid", m_valid, mv);
        if (mv) begin
            check("m_data", m_data, md);
            check("m_chan", m_chan, mc);
        end
        check("ovf", ovf, movf);
        check("empty", empty, memp);
    endtask

    // Apply inputs after a falling edge, record any transfer, advance the model, clock, compare.
    task automatic step(logic [NC-1:0] en, logic [NB-1:0] d, logic rdy, logic clr);
        out_en = en; io_out = d; m_ready = rdy; ovf_clr = clr;
        #1;
        if (m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_c.push_back(int'(m_chan));
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_valid"}, m_valid, 1'b0);
        check({tag, "_data"}, m_data, '0);
        check({tag, "_chan"}, m_chan, '0);
        check({tag, "_ovf"}, ovf, 4'b0000);
        check({tag, "_empty"}, empty, 4'b1111);
    endtask

    initial begin
        logic [NB-1:0] exp_ovf_drain[$];
        int thr;
        logic [NC-1:0] en;
        int r;

        rst = 1'b0; out_en = '0; io_out = '0; m_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        step('0, '0, 1'b1, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        check("idle_valid", m_valid, 1'b0);
        check("idle_empty", empty, 4'b1111);

        // Single word on channel 2.
        step(4'b0100, NB'(-5), 1'b1, 1'b0);
        check("single_not_yet", m_valid, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        check("single_valid", m_valid, 1'b1);
        check("single_data", m_data, 31'h7FFF_FFFB);
        check("single_chan", m_chan, 2'd2);
        step('0, '0, 1'b1, 1'b0);
        check("single_gone", m_valid, 1'b0);

        // Round robin over all four channels.
        step(4'b0001, 31'd10, 1'b0, 1'b0);
        step(4'b0010, 31'd11, 1'b0, 1'b0);
        step(4'b0100, 31'd12, 1'b0, 1'b0);
        step(4'b1000, 31'd13, 1'b0, 1'b0);
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 6; i++) step('0, '0, 1'b1, 1'b0);
        check("rr_count", got_d.size(), 4);
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            check("rr_chan", got_c[i], i);
            check("rr_data", got_d[i], 10 + i);
        end

        // Back-pressure holds the word stable and transfers it once.
        step(4'b0001, 31'd77, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step('0, '0, 1'b0, 1'b0);
            check("bp_hold_data", m_data, 31'd77);
            check("bp_hold_chan", m_chan, 2'd0);
        end
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 3; i++) step('0, '0, 1'b1, 1'b0);
        check("bp_once", got_d.size(), 1);
        if (got_d.size() > 0) check("bp_word", got_d[0], 31'd77);

        // Overflow: output register holds 100 while channel 1 receives 1..9.
        step(4'b0001, 31'd100, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 9; i++) step(4'b0010, NB'(i), 1'b0, 1'b0);
        check("ovf_set", ovf, 4'b0010);
        exp_ovf_drain.push_back(31'd100);
`ifdef OUT_COLLECT_DROP_OLDEST_EN
        for (int i = 2; i <= 9; i++) exp_ovf_drain.push_back(NB'(i));
`else
        for (int i = 1; i <= 8; i++) exp_ovf_drain.push_back(NB'(i));
`endif
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 12; i++) step('0, '0, 1'b1, 1'b0);
        check("ovf_drain_count", got_d.size(), 9);
        for (int i = 0; i < got_d.size() && i < 9; i++) check("ovf_drain_word", got_d[i], exp_ovf_drain[i]);
        check("ovf_sticky", ovf, 4'b0010);
        step('0, '0, 1'b1, 1'b1);
        check("ovf_clr", ovf, 4'b0000);

        // Reset in the middle of traffic.
        step(4'b0001, 31'd5, 1'b0, 1'b0);
        step(4'b0010, 31'd6, 1'b0, 1'b0);
        step(4'b0100, 31'd7, 1'b0, 1'b0);
        step(4'b1000, 31'd8, 1'b0, 1'b0);
        check("mid_valid", m_valid, 1'b1);
        check("mid_data", m_data, 31'd5);
        out_en = '0; m_ready = 1'b1;
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        got_d.delete(); got_c.delete();
        for (int i = 0; i < 5; i++) step('0, '0, 1'b1, 1'b0);
        check("midrst_no_stale", got_d.size(), 0);

        // Randomized traffic with varying consumer pressure.
        thr = 50;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 200 == 0) begin
                r = $urandom_range(0, 2);
                thr = (r == 0) ? 10 : (r == 1) ? 50 : 95;
            end
            r = $urandom_range(0, 9);
            if (r <= 5)      en = 4'b0001 << $urandom_range(0, 3);
            else if (r <= 7) en = '0;
            else if (r == 8) en = NC'($urandom);
            else             en = '1;
            step(en, NB'($urandom), ($urandom_range(0, 99) < thr), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
